// File: rtl/uart_pkg.sv
// UART buffer shared definitions:
// register map, STATUS/CTRL bit positions, FSM states.
package uart_pkg;
  localparam logic [3:0] ADDR_DATA   = 4'h0;
  localparam logic [3:0] ADDR_STATUS = 4'h4;
  localparam logic [3:0] ADDR_CTRL   = 4'h8;

  localparam int ST_TX_FULL  = 0;
  localparam int ST_RX_EMPTY = 1;
  localparam int ST_RX_OVR   = 2;
  localparam int ST_TX_DROP  = 3;
  localparam int ST_TX_CNT   = 7;
  localparam int ST_RX_CNT   = 16;

  localparam int CT_RX_IE    = 0;
  localparam int CT_TX_IE    = 1;
  localparam int CT_CLR_OVR  = 2;
  localparam int CT_CLR_DROP = 3;

  localparam logic [31:0] RD_EMPTY = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_STROBE,
    TX_WAIT
  } tx_state_e;

  typedef enum logic {
    RX_IDLE,
    RX_ACK
  } rx_state_e;
endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO; a pop frees the slot so a
// same-cycle push is accepted even when full.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_din,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_dout,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_count = r_count;
  assign o_dout  = r_mem[r_rptr];
  assign w_pop   = i_pop && !o_empty;
  assign w_push  = i_push && (!o_full || w_pop);

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_din;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/uart_buffer.sv
// CPU-side register block with TX/RX FIFOs in front
// of a UART core; strobes are stretched over clkdiv+1.
module uart_buffer #(
  parameter int DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] clkdiv,
  input  logic [3:0]  addr,
  input  logic        wr,
  input  logic        rd,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq,
  output logic        u_we,
  output logic [31:0] u_so,
  output logic        u_re,
  input  logic [31:0] u_si,
  input  logic        u_wa
);
  import uart_pkg::*;

  localparam int AW = $clog2(DEPTH);

  tx_state_e   r_tx_state;
  rx_state_e   r_rx_state;
  logic [31:0] r_tx_hold;
  logic [31:0] r_rx_hold;
  logic [31:0] r_rdata;
  logic [31:0] r_so;
  logic        r_we;
  logic        r_re;
  logic        r_rx_ie;
  logic        r_tx_ie;
  logic        r_rx_ovr;
  logic        r_tx_drop;

  logic        w_tx_push;
  logic        w_tx_pop;
  logic        w_tx_full;
  logic        w_tx_empty;
  logic [7:0]  w_tx_head;
  logic [AW:0] w_tx_cnt;
  logic        w_rx_push;
  logic        w_rx_pop;
  logic        w_rx_full;
  logic        w_rx_empty;
  logic [7:0]  w_rx_head;
  logic [AW:0] w_rx_cnt;
  logic        w_ctrl_wr;
  logic [31:0] w_status;
  logic [31:0] w_rd_val;
  logic        w_unused;

  assign w_tx_push = wr && (addr == ADDR_DATA);
  assign w_ctrl_wr = wr && (addr == ADDR_CTRL);
  assign w_tx_pop  = (r_tx_state == TX_IDLE)
                   && !w_tx_empty && !u_wa;
  assign w_rx_push = (r_rx_state == RX_IDLE) && !u_si[31];
  assign w_rx_pop  = rd && (addr == ADDR_DATA) && !w_rx_empty;
  assign w_unused  = ^{u_si[30:8], wdata[31:8]};

  sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_tx_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_tx_push),
    .i_din   (wdata[7:0]),
    .i_pop   (w_tx_pop),
    .o_dout  (w_tx_head),
    .o_full  (w_tx_full),
    .o_empty (w_tx_empty),
    .o_count (w_tx_cnt)
  );

  sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_rx_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_rx_push),
    .i_din   (u_si[7:0]),
    .i_pop   (w_rx_pop),
    .o_dout  (w_rx_head),
    .o_full  (w_rx_full),
    .o_empty (w_rx_empty),
    .o_count (w_rx_cnt)
  );

  always_comb begin
    w_status = '0;
    w_status[ST_RX_CNT +: 9] = 9'(w_rx_cnt);
    w_status[ST_TX_CNT +: 9] = 9'(w_tx_cnt);
    w_status[ST_TX_DROP]     = r_tx_drop;
    w_status[ST_RX_OVR]      = r_rx_ovr;
    w_status[ST_RX_EMPTY]    = w_rx_empty;
    w_status[ST_TX_FULL]     = w_tx_full;
  end

  always_comb begin
    w_rd_val = '0;
    unique case (1'b1)
      addr == ADDR_DATA:
        w_rd_val = w_rx_empty ? RD_EMPTY
                              : {24'h0, w_rx_head};
      addr == ADDR_STATUS: w_rd_val = w_status;
      addr == ADDR_CTRL:
        w_rd_val = {30'h0, r_tx_ie, r_rx_ie};
      default: w_rd_val = '0;
    endcase
  end

  // Sticky flags: a same-cycle error event wins over a clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rx_ie   <= 1'b0;
      r_tx_ie   <= 1'b0;
      r_rx_ovr  <= 1'b0;
      r_tx_drop <= 1'b0;
      r_rdata   <= '0;
    end else begin
      if (w_ctrl_wr) begin
        r_rx_ie <= wdata[CT_RX_IE];
        r_tx_ie <= wdata[CT_TX_IE];
        if (wdata[CT_CLR_OVR])  r_rx_ovr  <= 1'b0;
        if (wdata[CT_CLR_DROP]) r_tx_drop <= 1'b0;
      end
      if (w_tx_push && w_tx_full && !w_tx_pop)
        r_tx_drop <= 1'b1;
      if (w_rx_push && w_rx_full && !w_rx_pop)
        r_rx_ovr <= 1'b1;
      if (rd) r_rdata <= w_rd_val;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_tx_state <= TX_IDLE;
      r_tx_hold  <= '0;
      r_we       <= 1'b0;
      r_so       <= '0;
    end else begin
      unique case (r_tx_state)
        TX_IDLE: if (w_tx_pop) begin
          r_so       <= {24'h0, w_tx_head};
          r_we       <= 1'b1;
          r_tx_hold  <= clkdiv;
          r_tx_state <= TX_STROBE;
        end
        TX_STROBE: if (r_tx_hold == '0) begin
          r_we       <= 1'b0;
          r_tx_state <= TX_WAIT;
        end else begin
          r_tx_hold <= r_tx_hold - 32'd1;
        end
        TX_WAIT: if (!u_wa) r_tx_state <= TX_IDLE;
        default: r_tx_state <= TX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rx_state <= RX_IDLE;
      r_rx_hold  <= '0;
      r_re       <= 1'b0;
    end else begin
      unique case (r_rx_state)
        RX_IDLE: if (w_rx_push) begin
          r_re       <= 1'b1;
          r_rx_hold  <= clkdiv;
          r_rx_state <= RX_ACK;
        end
        RX_ACK: if (r_rx_hold == '0) begin
          r_re       <= 1'b0;
          r_rx_state <= RX_IDLE;
        end else begin
          r_rx_hold <= r_rx_hold - 32'd1;
        end
        default: r_rx_state <= RX_IDLE;
      endcase
    end
  end

  assign rdata = r_rdata;
  assign u_we  = r_we;
  assign u_so  = r_so;
  assign u_re  = r_re;
  assign irq   = (r_rx_ie & ~w_rx_empty)
               | (r_tx_ie & w_tx_empty);
endmodule
